// File: rtl/f1_start_seq.sv
// Formula-1 style start-light sequencer: lamps fill one per tick, hold, then go out.
// Build with F1_REACTION_EN defined to add driver reaction timing and jump-start detection.
module f1_start_seq #(
    parameter int N_LIGHTS = 8,
    parameter int HOLD_W   = 8,
    parameter int RT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                trigger,
    input  logic                abort,
    input  logic [HOLD_W-1:0]   hold_ticks,
    input  logic                react,
    output logic [N_LIGHTS-1:0] lights,
    output logic                busy,
    output logic                lights_out,
    output logic                react_valid,
    output logic [RT_W-1:0]     react_time,
    output logic                jump_start,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2,
        S_TIME = 2'd3
    } state_t;

    localparam logic [N_LIGHTS-1:0] LIGHT_FIRST = N_LIGHTS'(1);

    state_t              state_q;
    logic [N_LIGHTS-1:0] lights_q;
    logic                busy_q;
    logic                lights_out_q;
    logic [HOLD_W-1:0]   hold_cap_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [N_LIGHTS-1:0] lights_shift_d;

    assign lights_shift_d = {lights_q[N_LIGHTS-2:0], 1'b1};

`ifdef F1_REACTION_EN
    localparam logic [RT_W-1:0] RT_MAX  = '1;
    localparam logic [RT_W-1:0] RT_LAST = RT_MAX - 1'b1;

    logic [RT_W-1:0] rt_cnt_q;
    logic [RT_W-1:0] react_time_q;
    logic            react_valid_q;
    logic            jump_start_q;
`else
    logic unused_react;
    assign unused_react = react;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            lights_q     <= '0;
            busy_q       <= 1'b0;
            lights_out_q <= 1'b0;
            hold_cap_q   <= '0;
            hold_cnt_q   <= '0;
`ifdef F1_REACTION_EN
            rt_cnt_q      <= '0;
            react_time_q  <= '0;
            react_valid_q <= 1'b0;
            jump_start_q  <= 1'b0;
`endif
        end else begin
            lights_out_q <= 1'b0;
`ifdef F1_REACTION_EN
            react_valid_q <= 1'b0;
            jump_start_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (trigger && !abort) begin
                        state_q    <= S_FILL;
                        busy_q     <= 1'b1;
                        lights_q   <= LIGHT_FIRST;
                        hold_cap_q <= hold_ticks;
                    end
                end
                S_FILL, S_HOLD: begin
                    // abort beats a jump start, which beats the tick step
                    if (abort) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        lights_q <= '0;
`ifdef F1_REACTION_EN
                    end else if (react) begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        lights_q     <= '0;
                        jump_start_q <= 1'b1;
`endif
                    end else if (tick) begin
                        if (state_q == S_FILL) begin
                            if (&lights_q) begin
                                state_q    <= S_HOLD;
                                hold_cnt_q <= hold_cap_q;
                            end else begin
                                lights_q <= lights_shift_d;
                            end
                        end else if (hold_cnt_q == '0) begin
                            lights_q     <= '0;
                            lights_out_q <= 1'b1;
`ifdef F1_REACTION_EN
                            state_q      <= S_TIME;
                            rt_cnt_q     <= '0;
`else
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
`endif
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        end
                    end
                end
`ifdef F1_REACTION_EN
                S_TIME: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (react) begin
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                        react_time_q  <= rt_cnt_q;
                        react_valid_q <= 1'b1;
                    end else if (rt_cnt_q == RT_LAST) begin
                        // counter would reach all ones this edge: report a timeout
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                        react_time_q  <= RT_MAX;
                        react_valid_q <= 1'b1;
                    end else begin
                        rt_cnt_q <= rt_cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    lights_q <= '0;
                end
            endcase
        end
    end

    assign lights     = lights_q;
    assign busy       = busy_q;
    assign lights_out = lights_out_q;
    assign dbg_state  = state_q;

`ifdef F1_REACTION_EN
    assign react_valid = react_valid_q;
    assign react_time  = react_time_q;
    assign jump_start  = jump_start_q;
`else
    assign react_valid = 1'b0;
    assign react_time  = '0;
    assign jump_start  = 1'b0;
`endif

endmodule

// File: tb/tb_f1_start_seq.sv
// Directed bench for f1_start_seq with a lamp-count level reference model checked every cycle.
module tb_f1_start_seq;

`ifdef F1_REACTION_EN
    localparam bit REACT_EN = 1'b1;
`else
    localparam bit REACT_EN = 1'b0;
`endif
    localparam int RT_MAX = 65535;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b0;
    logic       trigger, abort, react;
    logic [7:0] hold_ticks;
    logic [7:0] lights;
    logic       busy, lights_out, react_valid, jump_start;
    logic [15:0] react_time;
    logic [1:0] dbg_state;

    logic       trigger2, react2, abort2;
    logic [7:0] lights2;
    logic       busy2, lo2, rv2, js2;
    logic [3:0] rt2;
    logic [1:0] dbg2;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  cmp_en = 1'b0;
    bit  rv_seen = 1'b0;
    int  cyc = 0;
    int  tick_cnt = 0;

    f1_start_seq #(.N_LIGHTS(8), .HOLD_W(8), .RT_W(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .abort(abort),
        .hold_ticks(hold_ticks), .react(react), .lights(lights), .busy(busy),
        .lights_out(lights_out), .react_valid(react_valid), .react_time(react_time),
        .jump_start(jump_start), .dbg_state(dbg_state)
    );

    f1_start_seq #(.N_LIGHTS(8), .HOLD_W(8), .RT_W(4)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .trigger(trigger2), .abort(abort2),
        .hold_ticks(hold_ticks), .react(react2), .lights(lights2), .busy(busy2),
        .lights_out(lo2), .react_valid(rv2), .react_time(rt2),
        .jump_start(js2), .dbg_state(dbg2)
    );

    // clock / tick generation
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        tick = ((cyc % 4) == 0);
    end

    always @(posedge clk) if (tick) tick_cnt = tick_cnt + 1;

    always @(negedge clk) if (react_valid || rv2) rv_seen = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: lamps lit, hold ticks seen, edges spent waiting for the driver
    int m_phase, m_lit, m_cap, m_hseen, m_edges, m_rt;
    bit m_lo, m_rv, m_js;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_lit = 0; m_cap = 0; m_hseen = 0; m_edges = 0; m_rt = 0;
            m_lo = 0; m_rv = 0; m_js = 0;
        end else begin
            m_lo = 0; m_rv = 0; m_js = 0;
            if (m_phase == 0) begin
                if (trigger && !abort) begin
                    m_phase = 1; m_lit = 1; m_cap = int'(hold_ticks);
                end
            end else if (abort) begin
                m_phase = 0; m_lit = 0;
            end else if (m_phase != 3 && REACT_EN && react) begin
                m_js = 1; m_phase = 0; m_lit = 0;
            end else if (m_phase == 1) begin
                if (tick) begin
                    if (m_lit == 8) begin m_phase = 2; m_hseen = 0; end
                    else m_lit = m_lit + 1;
                end
            end else if (m_phase == 2) begin
                if (tick) begin
                    m_hseen = m_hseen + 1;
                    if (m_hseen == m_cap + 1) begin
                        m_lo = 1; m_lit = 0; m_edges = 0;
                        m_phase = REACT_EN ? 3 : 0;
                    end
                end
            end else begin
                m_edges = m_edges + 1;
                if (react) begin
                    m_rt = m_edges - 1; m_rv = 1; m_phase = 0;
                end else if (m_edges == RT_MAX) begin
                    m_rt = RT_MAX; m_rv = 1; m_phase = 0;
                end
            end
        end
    end

    // scoreboard compare on every falling edge
    always @(negedge clk) begin
        logic [63:0] ones;
        logic [27:0] act_v, exp_v;
        if (cmp_en) begin
            ones  = (64'd1 << m_lit) - 64'd1;
            act_v = {lights, busy, lights_out, react_valid, jump_start, react_time};
            exp_v = {ones[7:0], (m_phase != 0), m_lo, m_rv, m_js, m_rt[15:0]};
            check("cycle_outputs", {36'd0, act_v}, {36'd0, exp_v});
        end
    end

    // driver tasks
    task automatic start_seq();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("start_lights", {56'd0, lights}, 64'h01);
        tick_cnt = 0;
    endtask

    task automatic wait_lo();
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (lights_out) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("lights_out_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic wait_lights(input logic [7:0] pat);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (lights == pat) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("lights_reached", {63'd0, seen}, 64'd1);
    endtask

    task automatic abort_pulse();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;
        rst = 1'b0; trigger = 1'b0; abort = 1'b0; react = 1'b0; hold_ticks = 8'd3;
        trigger2 = 1'b0; react2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lights", {56'd0, lights}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_react_time", {48'd0, react_time}, 64'd0);
        check("rst_lights_out", {63'd0, lights_out}, 64'd0);
        rst = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        // full sequence with hold of 3
        start_seq();
        wait_lo();
        check("fill_hold_ticks", 64'(tick_cnt), 64'd12);
        check("lo_lights", {56'd0, lights}, 64'd0);
`ifdef F1_REACTION_EN
        check("time_busy", {63'd0, busy}, 64'd1);
        repeat (25) @(negedge clk);
        react = 1'b1;
        @(negedge clk);
        check("react_valid", {63'd0, react_valid}, 64'd1);
        check("react_time_25", {48'd0, react_time}, 64'd25);
        check("react_busy_fall", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        check("react_held_idle", {63'd0, busy}, 64'd0);
        react = 1'b0;
`else
        check("lo_to_idle", {63'd0, busy}, 64'd0);
        react = 1'b1;
        repeat (2) @(negedge clk);
        react = 1'b0;
        check("react_ignored", {48'd0, react_time}, 64'd0);
`endif
        @(negedge clk);

        // premature react while lights show 07
        start_seq();
        wait_lights(8'h07);
        react = 1'b1;
        @(negedge clk);
        react = 1'b0;
`ifdef F1_REACTION_EN
        check("jump_start", {63'd0, jump_start}, 64'd1);
        check("jump_lights", {56'd0, lights}, 64'd0);
        check("jump_busy", {63'd0, busy}, 64'd0);
        check("jump_rt_kept", {48'd0, react_time}, 64'd25);
        @(negedge clk);
        check("jump_one_cycle", {63'd0, jump_start}, 64'd0);
`else
        check("no_jump_start", {63'd0, jump_start}, 64'd0);
        check("no_jump_busy", {63'd0, busy}, 64'd1);
        abort_pulse();
        check("abort_busy", {63'd0, busy}, 64'd0);
`endif
        @(negedge clk);

        // trigger during FILL, then abort coinciding with tick
        start_seq();
        wait_lights(8'h03);
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (tick) break;
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
        abort_pulse();
        check("abort_lights", {56'd0, lights}, 64'd0);
        check("abort_busy_fill", {63'd0, busy}, 64'd0);
        check("abort_no_pulse", {61'd0, jump_start, lights_out, react_valid}, 64'd0);

        // asynchronous reset during HOLD
        hold_ticks = 8'd3;
        start_seq();
        wait_lights(8'hFF);
        repeat (6) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst_lights", {56'd0, lights}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("post_rst_start", {56'd0, lights}, 64'h01);
        check("post_rst_busy", {63'd0, busy}, 64'd1);
        abort_pulse();
        @(negedge clk);

        // zero hold: lights out on the first HOLD tick
        hold_ticks = 8'd0;
        start_seq();
        wait_lo();
        check("zero_hold_ticks", 64'(tick_cnt), 64'd9);
`ifdef F1_REACTION_EN
        check("zero_hold_busy", {63'd0, busy}, 64'd1);
        abort_pulse();
`else
        check("zero_hold_idle", {63'd0, busy}, 64'd0);
`endif
        @(negedge clk);

        // narrow reaction counter instance
        trigger2 = 1'b1;
        @(negedge clk);
        trigger2 = 1'b0;
        check("dut2_start", {56'd0, lights2}, 64'h01);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (lo2) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("dut2_lo_seen", {63'd0, seen}, 64'd1);
`ifdef F1_REACTION_EN
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (rv2) break;
        end
        check("timeout_latency", 64'(cnt), 64'd15);
        check("timeout_rt", {60'd0, rt2}, 64'd15);
        check("timeout_busy", {63'd0, busy2}, 64'd0);
        trigger2 = 1'b1;
        @(negedge clk);
        trigger2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (lo2) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("dut2_lo_seen2", {63'd0, seen}, 64'd1);
        react2 = 1'b1;
        @(negedge clk);
        react2 = 1'b0;
        check("first_cycle_valid", {63'd0, rv2}, 64'd1);
        check("first_cycle_rt", {60'd0, rt2}, 64'd0);
`else
        check("dut2_idle_after_lo", {63'd0, busy2}, 64'd0);
        repeat (20) @(negedge clk);
        check("react_valid_never", {63'd0, rv_seen}, 64'd0);
`endif
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/f1_start_seq.md
F1_START_SEQ -- requirements
Module: f1_start_seq

Interface
REQ-001 Parameter N_LIGHTS, default 8, number of lights in the gantry; legal range 2..32.
REQ-002 Parameter HOLD_W, default 8, width of the hold-delay count in ticks.
REQ-003 Parameter RT_W, default 16, width of the reaction-time count in clk cycles.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 tick  input  1  one-cycle step enable, paces the FILL and HOLD states.
REQ-007 trigger  input  1  start request, level-sampled each clk.
REQ-008 abort  input  1  synchronous cancel to IDLE.
REQ-009 hold_ticks  input  HOLD_W  ticks from all-lights-on to lights-out, captured on start.
REQ-010 react  input  1  driver button, level-sampled each clk.
REQ-011 lights  output  N_LIGHTS  lamp drive; bit 0 is the first lamp lit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 lights_out  output  1  one-cycle pulse on the edge where all lights extinguish.
REQ-014 react_valid  output  1  one-cycle pulse when react_time is updated.
REQ-015 react_time  output  RT_W  registered reaction time in clk cycles, holds until the next update.
REQ-016 jump_start  output  1  one-cycle pulse on a premature react.

Function
REQ-017 States: IDLE, FILL, HOLD, TIME; all outputs registered; no latches.
REQ-018 IDLE: lights=0; trigger=1 at an edge -> FILL, lights=1, hold_ticks captured, no tick needed.
REQ-019 trigger outside IDLE is ignored; a running sequence is never restarted.
REQ-020 FILL: on each tick, lights={lights[N_LIGHTS-2:0],1'b1} until all ones; a tick with lights all ones -> HOLD, hold counter loaded with captured hold_ticks.
REQ-021 Full pattern: reached N_LIGHTS-1 ticks after entry, shown at least one tick period before HOLD.
REQ-022 HOLD: counter decrements on tick; a tick at count 0 -> lights=0, lights_out=1 for that cycle, enter TIME; hold_ticks=0 extinguishes on first HOLD tick.
REQ-023 TIME: reaction counter cleared on entry, +1 per clk, saturates at 2^RT_W-1.
REQ-024 TIME: react=1 -> react_time=counter value, react_valid=1, IDLE; react on the first TIME cycle gives react_time=0.
REQ-025 TIME: counter saturated with no react -> react_time=all ones, react_valid=1, IDLE (timeout).
REQ-026 react=1 in FILL or HOLD -> jump_start=1, lights=0, IDLE, react_time unchanged.
REQ-027 Priority per edge: abort > react (jump start) > tick; abort -> IDLE, lights=0, no pulse output.
REQ-028 react held from TIME into IDLE does not retrigger anything; IDLE ignores react.

Reset
REQ-029 rst=0 asynchronously forces IDLE, lights=0, busy=0, lights_out=0, react_valid=0, jump_start=0, react_time=0, counters=0.
REQ-030 Reset mid-sequence discards the sequence; the first edge after release obeys REQ-018.

Configuration
REQ-031 Macro F1_REACTION_EN defined: TIME state, react_time, react_valid, jump_start, REQ-023..REQ-028 fully present.
REQ-032 F1_REACTION_EN undefined: no TIME state; lights-out edge -> IDLE directly; react ignored; react_valid, jump_start, react_time tied 0.

Verification
REQ-033 N_LIGHTS=8, tick every 4 clk, hold_ticks=3, trigger pulse -> lights 01,03,..,FF one step per tick, then 3 HOLD ticks, lights_out pulse, lights=00.
REQ-034 Same setup, react asserted 25 clk after lights_out -> react_valid pulse, react_time=25, busy falls next edge.
REQ-035 react asserted while lights=07 -> jump_start pulse, lights=00, IDLE, react_time keeps prior value.
REQ-036 RT_W=4, no react after lights-out -> react_time=15, react_valid pulse 15 clk after TIME entry.
REQ-037 abort and tick together in FILL, and rst=0 mid-HOLD -> lights=00, IDLE; trigger during FILL has no effect.
REQ-038 Build without F1_REACTION_EN, hold_ticks=0 -> lights_out on first HOLD tick, then IDLE; react_valid never asserts.
